// File: rtl/mmio_map_pkg.sv
// Shared MMIO map for the frame sequencer: register selectors, register indices,
// the coprocessor base address and the sequencer FSM state type.
package mmio_map_pkg;

  localparam logic [12:0] MMIO_BASE = 13'h1000;

  localparam logic [3:0] SEL_PHYS = 4'd0;
  localparam logic [3:0] SEL_CTRL = 4'd4;
  localparam logic [3:0] SEL_VGA  = 4'd8;
  localparam logic [3:0] SEL_COLL = 4'd12;

  localparam logic [2:0] SPEC_POS    = 3'd0;
  localparam logic [2:0] SPEC_CTRL   = 3'd4;
  localparam logic [2:0] SPEC_COLLIS = 3'd7;

  localparam int OPS_PER_PLAYER = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

  // Which per-player latch an op reads into or writes out of.
  typedef enum logic [1:0] {
    LAT_POS = 2'd0,
    LAT_COL = 2'd1,
    LAT_CTL = 2'd2
  } lat_sel_e;

  function automatic logic [12:0] mmio_addr(input logic [3:0] sel, input logic [2:0] spec);
    return MMIO_BASE | {2'b00, sel, 7'b000_0000} | {8'h00, spec, 2'b00};
  endfunction

endpackage

// File: rtl/frame_seq_op_rom.sv
// Combinational op table: op index -> direction, MMIO address and which latch
// supplies write data or receives read data.
module frame_seq_op_rom
  import mmio_map_pkg::*;
(
  input  logic [3:0]  index,
  output logic        is_write,
  output logic [12:0] address,
  output lat_sel_e    src_sel,
  output lat_sel_e    dst_sel
);

  logic       player;
  logic [2:0] op;
  logic [3:0] sel_phys;
  logic [3:0] sel_ctrl;
  logic [3:0] sel_vga;
  logic [3:0] sel_coll;

  always_comb begin
    player   = (index >= 4'd7);
    op       = player ? 3'(index - 4'd7) : index[2:0];
    sel_phys = SEL_PHYS | {3'b000, player};
    sel_ctrl = SEL_CTRL | {3'b000, player};
    sel_vga  = SEL_VGA  | {3'b000, player};
    sel_coll = SEL_COLL | {3'b000, player};
  end

  always_comb begin
    is_write = 1'b0;
    address  = mmio_addr(sel_phys, SPEC_POS);
    src_sel  = LAT_POS;
    dst_sel  = LAT_POS;
    case (op)
      3'd0: begin
        address = mmio_addr(sel_phys, SPEC_POS);
        dst_sel = LAT_POS;
      end
      3'd1: begin
        is_write = 1'b1;
        address  = mmio_addr(sel_coll, SPEC_POS);
        src_sel  = LAT_POS;
      end
      3'd2: begin
        is_write = 1'b1;
        address  = mmio_addr(sel_vga, SPEC_POS);
        src_sel  = LAT_POS;
      end
      3'd3: begin
        address = mmio_addr(sel_coll, SPEC_POS);
        dst_sel = LAT_COL;
      end
      3'd4: begin
        is_write = 1'b1;
        address  = mmio_addr(sel_phys, SPEC_COLLIS);
        src_sel  = LAT_COL;
      end
      3'd5: begin
        address = mmio_addr(sel_ctrl, SPEC_POS);
        dst_sel = LAT_CTL;
      end
      3'd6: begin
        is_write = 1'b1;
        address  = mmio_addr(sel_phys, SPEC_CTRL);
        src_sel  = LAT_CTL;
      end
      default: begin
        is_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mmio_frame_sequencer.sv
// Per-frame MMIO bus master: on each frame tick it walks the op table for every
// player, moving position, collision and controller words between peripherals.
module mmio_frame_sequencer
  import mmio_map_pkg::*;
#(
  parameter int READ_WAIT   = 2,
  parameter int WRITE_HOLD  = 1,
  parameter int NUM_PLAYERS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [12:0] address,
  output logic [31:0] wr_data,
  output logic        wren,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count,
  output seq_state_e  fsm_state
);

  localparam logic [3:0] LAST_OP    = 4'(OPS_PER_PLAYER * NUM_PLAYERS - 1);
  localparam logic [7:0] READ_LOAD  = 8'(READ_WAIT - 1);
  localparam logic [7:0] WRITE_LOAD = 8'(WRITE_HOLD - 1);

  seq_state_e  state;
  logic [3:0]  op_idx;
  logic [7:0]  wait_cnt;
  logic        pending;
  logic        wren_q;
  logic [31:0] pos_q;
  logic [31:0] col_q;
  logic [31:0] ctl_q;
  logic [31:0] wr_src;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  logic        rom_is_write;
  logic [12:0] rom_addr;
  lat_sel_e    rom_src;
  lat_sel_e    rom_dst;

  frame_seq_op_rom u_op_rom (
    .index    (op_idx),
    .is_write (rom_is_write),
    .address  (rom_addr),
    .src_sel  (rom_src),
    .dst_sel  (rom_dst)
  );

  always_comb begin
    case (rom_src)
      LAT_COL: wr_src = col_q;
      LAT_CTL: wr_src = ctl_q;
      default: wr_src = pos_q;
    endcase
  end

  // Bus handshake: bus_req is held from REQ until the last op's NEXT; we own the
  // bus only while bus_gnt is high, so wren is gated by the grant combinationally
  // and a lost grant aborts the current op, which is replayed after re-grant.
  assign wren          = wren_q & bus_gnt;
  assign frame_count   = frame_cnt;
  assign overrun_count = overrun_cnt;
  assign fsm_state     = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op_idx      <= '0;
      wait_cnt    <= '0;
      pending     <= 1'b0;
      wren_q      <= 1'b0;
      pos_q       <= '0;
      col_q       <= '0;
      ctl_q       <= '0;
      bus_req     <= 1'b0;
      address     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      frame_done <= 1'b0;

      // One tick may wait behind the running frame; any further tick is dropped.
      if (frame_tick && state != ST_IDLE) begin
        if (!pending) begin
          pending <= 1'b1;
        end else if (overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (frame_tick && enable) begin
            state   <= ST_REQ;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            op_idx  <= '0;
          end
        end

        ST_REQ: begin
          if (bus_gnt) begin
            state <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (!bus_gnt) begin
            state <= ST_REQ;
          end else begin
            address  <= rom_addr;
            wr_data  <= wr_src;
            wren_q   <= rom_is_write;
            wait_cnt <= rom_is_write ? WRITE_LOAD : READ_LOAD;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!bus_gnt) begin
            wren_q <= 1'b0;
            state  <= ST_REQ;
          end else if (wait_cnt == 8'd0) begin
            if (!rom_is_write) begin
              case (rom_dst)
                LAT_COL: col_q <= rd_data;
                LAT_CTL: ctl_q <= rd_data;
                default: pos_q <= rd_data;
              endcase
            end
            wren_q <= 1'b0;
            state  <= ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end

        // The op has completed here, so a lost grant only defers the next op.
        ST_NEXT: begin
          if (op_idx == LAST_OP) begin
            state      <= ST_DONE;
            op_idx     <= '0;
            bus_req    <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            op_idx <= op_idx + 4'd1;
            state  <= bus_gnt ? ST_ADDR : ST_REQ;
          end
        end

        ST_DONE: begin
          pending <= 1'b0;
          if (enable && (pending || frame_tick)) begin
            state   <= ST_REQ;
            bus_req <= 1'b1;
            op_idx  <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bus_req <= 1'b0;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_frame_sequencer.sv
// Self-checking bench for mmio_frame_sequencer: a table-driven MMIO slave, an
// expected-write queue built from the per-player op rules, and scenario checks.
module tb_mmio_frame_sequencer;
  import mmio_map_pkg::*;

  localparam int NP               = 2;
  localparam int WRITES_PER_FRAME = 4 * NP;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        frame_tick;
  logic        bus_req;
  logic        bus_gnt;
  logic [12:0] address;
  logic [31:0] wr_data;
  logic        wren;
  logic [31:0] rd_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  seq_state_e  fsm_state;

  mmio_frame_sequencer #(.READ_WAIT(2), .WRITE_HOLD(1), .NUM_PLAYERS(NP)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .frame_tick    (frame_tick),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .address       (address),
    .wr_data       (wr_data),
    .wren          (wren),
    .rd_data       (rd_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [44:0] exp_q[$];
  logic [44:0] log_w[$];
  logic [44:0] mon_w;
  int          writes_in_frame = 0;
  logic        monitor_on = 1'b0;
  logic        capture = 1'b0;
  logic        rand_gnt = 1'b0;

  logic [31:0] pos_v[NP];
  logic [31:0] col_v[NP];
  logic [31:0] ctl_v[NP];

  int   exp_frames = 0;
  int   exp_overrun = 0;
  bit   m_pend = 1'b0;

  function automatic logic [12:0] reg_addr(input int sel, input int spec);
    return 13'(4096 + sel * 128 + spec * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // MMIO slave: read data comes from per-register tables, independent of writes.
  always_comb begin
    rd_data = 32'hBAD0_0000;
    for (int p = 0; p < NP; p++) begin
      if (address == reg_addr(p, 0))      rd_data = pos_v[p];
      if (address == reg_addr(12 + p, 0)) rd_data = col_v[p];
      if (address == reg_addr(4 + p, 0))  rd_data = ctl_v[p];
    end
  end

  // Writes a frame must produce, in order, from the current read tables.
  task automatic push_frame();
    for (int p = 0; p < NP; p++) begin
      exp_q.push_back({reg_addr(12 + p, 0), pos_v[p]});
      exp_q.push_back({reg_addr(8 + p, 0),  pos_v[p]});
      exp_q.push_back({reg_addr(p, 7),      col_v[p]});
      exp_q.push_back({reg_addr(p, 4),      ctl_v[p]});
    end
  endtask

  task automatic new_data();
    for (int p = 0; p < NP; p++) begin
      pos_v[p] = $urandom();
      col_v[p] = $urandom();
      ctl_v[p] = $urandom();
    end
  endtask

  task automatic model_busy_tick();
    if (!m_pend) m_pend = 1'b1;
    else if (exp_overrun < 255) exp_overrun++;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (reset && monitor_on) begin
      if (wren) begin
        check("wren_needs_gnt_req", {62'b0, bus_gnt, bus_req}, 64'd3);
        if (exp_q.size() == 0) begin
          check("write_unexpected", {19'b0, address, wr_data}, 64'd0);
        end else begin
          mon_w = exp_q.pop_front();
          check("write_addr", {51'b0, address}, {51'b0, mon_w[44:32]});
          check("write_data", {32'b0, wr_data}, {32'b0, mon_w[31:0]});
        end
        writes_in_frame++;
        if (capture) log_w.push_back({address, wr_data});
      end
      if (bus_req && !bus_gnt) check("wren_low_without_gnt", {63'b0, wren}, 64'd0);
      if (!busy) check("idle_no_req", {63'b0, bus_req}, 64'd0);
      if (frame_done) begin
        check("writes_per_frame", 64'(writes_in_frame), 64'(WRITES_PER_FRAME));
        writes_in_frame = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
    if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) step();
    while (busy && n < 4000) begin
      step();
      n++;
    end
    check(name, {63'b0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_wren_busy_done"}, {60'b0, bus_req, wren, busy, frame_done}, 64'd0);
    check({tag, "_addr_data"}, {19'b0, address, wr_data}, 64'd0);
    check({tag, "_counters"}, {40'b0, frame_count, overrun_count}, 64'd0);
    check({tag, "_state"}, {61'b0, fsm_state}, {61'b0, ST_IDLE});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    reset      = 1'b0;
    enable     = 1'b0;
    frame_tick = 1'b0;
    bus_gnt    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pos_v[p] = '0;
      col_v[p] = '0;
      ctl_v[p] = '0;
    end
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1;
    monitor_on = 1'b1;
    step();

    // Directed frame with fixed data, latency and literal write list.
    bus_gnt  = 1'b1;
    enable   = 1'b1;
    pos_v[0] = 32'h016000FA;
    col_v[0] = 32'h5;
    ctl_v[0] = 32'hA;
    pos_v[1] = 32'h02340111;
    col_v[1] = 32'h3;
    ctl_v[1] = 32'hC;
    push_frame();
    capture = 1'b1;
    tick();
    n = 0;
    while (!frame_done && n < 300) begin
      step();
      n++;
    end
    check("frame_latency", 64'(n), 64'd49);
    check("frame_count_first", {48'b0, frame_count}, 64'd1);
    step();
    check("frame_done_pulse", {63'b0, frame_done}, 64'd0);
    wait_idle("idle_after_first");
    capture = 1'b0;
    exp_frames = 1;
    check("log_size", 64'(log_w.size()), 64'd8);
    if (log_w.size() >= 8) begin
      check("lit_w0", {19'b0, log_w[0]}, {19'b0, 13'h1600, 32'h016000FA});
      check("lit_w1", {19'b0, log_w[1]}, {19'b0, 13'h1400, 32'h016000FA});
      check("lit_w2", {19'b0, log_w[2]}, {19'b0, 13'h101C, 32'h5});
      check("lit_w3", {19'b0, log_w[3]}, {19'b0, 13'h1010, 32'hA});
      check("lit_w4", {19'b0, log_w[4]}, {19'b0, 13'h1680, 32'h02340111});
      check("lit_w5", {19'b0, log_w[5]}, {19'b0, 13'h1480, 32'h02340111});
      check("lit_w6", {19'b0, log_w[6]}, {19'b0, 13'h109C, 32'h3});
      check("lit_w7", {19'b0, log_w[7]}, {19'b0, 13'h1090, 32'hC});
    end
    check("queue_drained_first", 64'(exp_q.size()), 64'd0);

    // Grant lost for 5 cycles during the first write's hold.
    new_data();
    push_frame();
    tick();
    n = 0;
    while (!wren && n < 100) begin
      step();
      n++;
    end
    check("op1_reached", {63'b0, wren}, 64'd1);
    check("op1_addr", {51'b0, address}, 64'h1600);
    bus_gnt = 1'b0;
    #1;
    check("wren_drop_same_cycle", {63'b0, wren}, 64'd0);
    repeat (5) begin
      step();
      check("wren_low_during_drop", {63'b0, wren}, 64'd0);
      check("req_held_during_drop", {63'b0, bus_req}, 64'd1);
    end
    bus_gnt = 1'b1;
    wait_idle("idle_after_drop");
    exp_frames++;
    check("frame_count_drop", {48'b0, frame_count}, 64'(exp_frames));
    check("queue_drained_drop", 64'(exp_q.size()), 64'd0);

    // Random data with a randomly toggling grant.
    for (int f = 0; f < 4; f++) begin
      new_data();
      push_frame();
      rand_gnt = 1'b1;
      tick();
      wait_idle("idle_random_gnt");
      rand_gnt = 1'b0;
      bus_gnt  = 1'b1;
      exp_frames++;
      check("frame_count_random", {48'b0, frame_count}, 64'(exp_frames));
    end
    check("queue_drained_random", 64'(exp_q.size()), 64'd0);

    // Three ticks in one frame: one pending frame, one overrun.
    new_data();
    push_frame();
    push_frame();
    tick();
    repeat (10) step();
    tick();
    model_busy_tick();
    repeat (10) step();
    tick();
    model_busy_tick();
    wait_idle("idle_after_pending");
    m_pend = 1'b0;
    exp_frames += 2;
    check("frame_count_pending", {48'b0, frame_count}, 64'(exp_frames));
    check("overrun_one", {56'b0, overrun_count}, 64'(exp_overrun));

    // Overrun saturation while the bus is withheld.
    new_data();
    push_frame();
    push_frame();
    tick();
    bus_gnt    = 1'b0;
    frame_tick = 1'b1;
    repeat (100) begin
      step();
      model_busy_tick();
    end
    check("overrun_partial", {56'b0, overrun_count}, 64'(exp_overrun));
    repeat (200) begin
      step();
      model_busy_tick();
    end
    frame_tick = 1'b0;
    check("overrun_saturated", {56'b0, overrun_count}, 64'(exp_overrun));
    bus_gnt = 1'b1;
    wait_idle("idle_after_saturate");
    m_pend = 1'b0;
    exp_frames += 2;
    check("frame_count_saturate", {48'b0, frame_count}, 64'(exp_frames));
    check("overrun_still_ff", {56'b0, overrun_count}, 64'hFF);

    // Frame counter wrap.
    dut.frame_cnt = 16'hFFFF;
    exp_frames    = 16'hFFFF;
    new_data();
    push_frame();
    tick();
    wait_idle("idle_after_wrap");
    exp_frames = (exp_frames + 1) % 65536;
    check("frame_count_wrap", {48'b0, frame_count}, 64'(exp_frames));

    // Disable mid-frame with a pending tick: no second frame.
    new_data();
    push_frame();
    tick();
    repeat (10) step();
    tick();
    model_busy_tick();
    repeat (5) step();
    enable = 1'b0;
    wait_idle("idle_after_disable");
    m_pend = 1'b0;
    exp_frames++;
    repeat (60) step();
    check("no_second_frame", {48'b0, frame_count}, 64'(exp_frames));
    check("state_idle_disabled", {61'b0, fsm_state}, {61'b0, ST_IDLE});
    tick();
    repeat (5) step();
    check("tick_ignored_disabled", {63'b0, busy}, 64'd0);
    enable = 1'b1;
    push_frame();
    tick();
    wait_idle("idle_after_reenable");
    exp_frames++;
    check("frame_count_reenable", {48'b0, frame_count}, 64'(exp_frames));
    check("queue_drained_enable", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while a write is being held.
    new_data();
    push_frame();
    tick();
    n = 0;
    while (!wren && n < 100) begin
      step();
      n++;
    end
    check("write_before_reset", {63'b0, wren}, 64'd1);
    reset = 1'b0;
    #1;
    check("reset_wren_async", {63'b0, wren}, 64'd0);
    monitor_on = 1'b0;
    exp_q.delete();
    writes_in_frame = 0;
    exp_frames  = 0;
    exp_overrun = 0;
    m_pend      = 1'b0;
    step();
    step();
    check_all_zero("reset_mid");
    reset = 1'b1;
    step();
    check_all_zero("after_release");
    monitor_on = 1'b1;

    // One clean frame after reset.
    new_data();
    push_frame();
    tick();
    wait_idle("idle_after_reset");
    exp_frames++;
    check("frame_count_post_reset", {48'b0, frame_count}, 64'(exp_frames));
    check("overrun_post_reset", {56'b0, overrun_count}, 64'(exp_overrun));
    check("queue_drained_final", 64'(exp_q.size()), 64'd0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
